// File: rtl/timer_ctrl.sv
// timer_ctrl - prescaled period counter sequencer for periodic ticks and
// one-shot delays.
//
// A start command latches period/presc/oneshot and enters RUN. A prescaler
// counts 0..presc_q; each wrap is a "step" that advances the main count.
// When the main count reaches period_q-1 on a step it wraps to 0 and a
// registered one-cycle tick is raised. In one-shot mode the same edge returns
// to IDLE and raises done alongside tick.
//
// Ports:
//   clk      system clock, rising edge
//   rst_     asynchronous active-low reset
//   start    start/restart command (ignored when stop is also high)
//   stop     stop command, highest priority
//   pause    level; holds the counters while high
//   oneshot  mode latched at start (1 = one-shot, 0 = periodic)
//   period   ticks per event, latched at start (0 behaves as 1)
//   presc    prescaler value, latched at start (divide ratio presc+1)
//   busy     high in RUN and PAUSED
//   tick     one-cycle pulse on every period expiry
//   done     one-cycle pulse on one-shot completion, coincident with tick
//   count    current main count
//
// Optional feature macro: TIMER_CTRL_IRQ_EN
//   Adds irq_clr input and sticky irq output. irq is set in the cycle tick
//   is high; irq_clr clears it at the next edge, a simultaneous set wins.

module timer_ctrl #(
    parameter int PRESC_MAX = 50,
    parameter int W         = 16
) (
`ifdef TIMER_CTRL_IRQ_EN
    input  logic                         irq_clr,
    output logic                         irq,
`endif
    input  logic                         clk,
    input  logic                         rst_,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         pause,
    input  logic                         oneshot,
    input  logic [W-1:0]                 period,
    input  logic [$clog2(PRESC_MAX)-1:0] presc,
    output logic                         busy,
    output logic                         tick,
    output logic                         done,
    output logic [W-1:0]                 count
);

    localparam int PW = $clog2(PRESC_MAX);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  count_q, count_d;
    logic [PW-1:0] psc_q, psc_d;
    logic [W-1:0]  period_q, period_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          oneshot_q, oneshot_d;
    logic          tick_q, tick_d;
    logic          done_q, done_d;

    logic [W-1:0]  eff_period;
    logic [W:0]    last_cnt;
    logic          step;
    logic          wrap_cnt;

    // period 0 behaves as period 1; last_cnt is formed one bit wider so the
    // subtraction can never underflow.
    assign eff_period = (period_q == '0) ? {{(W-1){1'b0}}, 1'b1} : period_q;
    assign last_cnt   = {1'b0, eff_period} - {{W{1'b0}}, 1'b1};
    assign step       = (psc_q == presc_q);
    assign wrap_cnt   = ({1'b0, count_q} >= last_cnt);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q   <= IDLE;
            count_q   <= '0;
            psc_q     <= '0;
            period_q  <= '0;
            presc_q   <= '0;
            oneshot_q <= 1'b0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            psc_q     <= psc_d;
            period_q  <= period_d;
            presc_q   <= presc_d;
            oneshot_q <= oneshot_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        psc_d     = psc_q;
        period_d  = period_q;
        presc_d   = presc_q;
        oneshot_d = oneshot_q;
        tick_d    = 1'b0;
        done_d    = 1'b0;

        if (stop) begin
            state_d = IDLE;
            count_d = '0;
            psc_d   = '0;
        end else if (start) begin
            // Restart discards any tick that would have fallen on this edge.
            state_d   = RUN;
            count_d   = '0;
            psc_d     = '0;
            period_d  = period;
            presc_d   = presc;
            oneshot_d = oneshot;
        end else begin
            case (state_q)
                RUN, PAUSED: begin
                    // In PAUSED nothing moves until pause drops; the release
                    // cycle already counts, as a RUN cycle would.
                    if (!(state_q == PAUSED && pause)) begin
                        state_d = pause ? PAUSED : RUN;
                        if (step && wrap_cnt) begin
                            // A wrap step still completes when pause rises
                            // in the same cycle.
                            tick_d  = 1'b1;
                            count_d = '0;
                            psc_d   = '0;
                            if (oneshot_q) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end else if (!pause) begin
                            psc_d = step ? '0 : psc_q + 1'b1;
                            if (step) count_d = count_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state_q != IDLE);
    assign tick  = tick_q;
    assign done  = done_q;
    assign count = count_q;

`ifdef TIMER_CTRL_IRQ_EN
    // Set from the same next-state term that raises tick, so irq appears
    // together with tick and beats a clear on that edge.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)        irq <= 1'b0;
        else if (tick_d)  irq <= 1'b1;
        else if (irq_clr) irq <= 1'b0;
    end
`endif

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
Sequencer for a prescaled period counter, used for periodic ticks and one-shot delays (e.g. LED blink, debounce windows, polling intervals). Latches the configuration on a start command. Runs a prescaler stage and a main count stage. Supports pause/resume/stop and emits single-cycle tick/done events. Sits between control logic (CPU-side register block or FSM) and any consumer that needs timed enables.

Parameters:
PRESC_MAX, 50, prescaler range; divide ratio is presc+1, so presc must be <= PRESC_MAX-1; presc width is $clog2(PRESC_MAX)
W, 16, width of period and count

Ports:
clk  in  1  system clock, all state changes on rising edge
rst_  in  1  asynchronous active-low reset
start  in  1  start/restart command, sampled each cycle
stop  in  1  stop command, sampled each cycle
pause  in  1  level; holds all counters while high in RUN
oneshot  in  1  mode, latched at start: 1 = one-shot, 0 = periodic
period  in  W  ticks per event, latched at start
presc  in  $clog2(PRESC_MAX)  prescaler value, latched at start
busy  out  1  high in RUN and PAUSED
tick  out  1  registered 1-cycle pulse on every period expiry
done  out  1  registered 1-cycle pulse on one-shot completion, coincident with tick
count  out  W  current main count value

Behaviour:
- Reset (async, rst_ low): state=IDLE; busy=0, tick=0, done=0, count=0; prescaler counter=0; latched config=0.
- States: IDLE, RUN, PAUSED.
- IDLE:
  - start=1 and stop=0 -> RUN at next edge.
  - At that edge: latch period/presc/oneshot; count=0; prescaler=0.
- RUN, prescaler:
  - Prescaler counts 0..presc_q, then wraps to 0.
  - Wrap cycle = "step".
  - presc_q=0 makes every RUN cycle a step.
- RUN, main count on each step:
  - If count < period_q-1: count+1.
  - Otherwise: count wraps to 0 and tick=1 in the following cycle.
  - One-shot: the same edge moves state to IDLE, with done=1 and busy=0 in the following cycle; count returns to 0.
- Tick timing: the first tick is visible period_q*(presc_q+1) cycles after the edge that entered RUN. Periodic ticks repeat with that spacing.
- period_q=0 is treated as 1, i.e. a tick on every step.
- pause=1 in RUN -> PAUSED. All counters hold; no tick. pause=0 in PAUSED -> RUN and counting continues from the held values.
- Pause edge case: pause asserted in the step cycle where count wraps still produces that tick; pause takes effect from the next cycle.
- stop=1 in RUN or PAUSED -> IDLE at next edge; count=0; prescaler=0; no tick or done for that edge.
- Priority: stop > start > pause.
  - start in RUN/PAUSED restarts: re-latch config, zero counters, enter RUN, and suppress any tick due that edge.
  - start together with stop in any state -> IDLE.
- Config inputs are ignored except on the start edge; changing them mid-run has no effect.
- busy goes high the cycle after start is accepted.
- tick and done are never asserted for more than one consecutive cycle unless period_q*(presc_q+1)=1 in periodic mode, in which case tick stays high every cycle.
- Counters are unsigned. Width rules:
  - prescaler comparison uses $clog2(PRESC_MAX) bits;
  - main comparison uses W bits;
  - period_q-1 is evaluated in W+1 bits to avoid underflow.

Optional Feature:
TIMER_CTRL_IRQ_EN
- Defined: adds input irq_clr (1) and output irq (1).
  - irq is set sticky in the same cycle tick is high, and is reset to 0.
  - irq_clr=1 clears irq at next edge; a simultaneous set wins over clear.
- Undefined: irq and irq_clr ports do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset mid-run: rst_ low for 1 cycle while count=5 -> count=0, busy=0, tick=0 immediately (asynchronous); stays IDLE after release.
- Periodic: period=4, presc=0, oneshot=0, start pulse -> busy=1 next cycle; tick every 4 cycles, first at cycle 4 after RUN entry; count sequence 0,1,2,3,0.
- Prescaled one-shot: period=3, presc=2, oneshot=1 -> single tick+done pulse 9 cycles after RUN entry, then busy=0, count=0; no further ticks over 50 cycles.
- Pause/resume: period=10, presc=0; pause for 7 cycles when count=4 -> count holds at 4, no tick; resume -> tick 6 cycles after pause release.
- Stop/start collisions: start+stop together in RUN -> IDLE, busy=0. start alone when count=9 of period=10 -> no tick that edge, count=0, new config latched.
- period=0: presc=1, periodic -> tick every 2 cycles. With TIMER_CTRL_IRQ_EN: irq=1 after first tick; irq_clr coinciding with a tick leaves irq=1.
